// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU types: operand width, funct3 encodings, in-flight tag.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_IDX_W = 8;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  // Index field is wide enough for any practical requester count.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin one-hot grant starting at i_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_vld
);

  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_sel;

  // Requests at or above the pointer win first; otherwise wrap to the bottom.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi[i] = i_req[i] && (IDX_W'(i) >= i_ptr);
    end
  end

  assign w_sel       = (|w_hi) ? w_hi : i_req;
  assign o_grant     = w_sel & (~w_sel + NREQ'(1));
  assign o_grant_vld = |i_req;

  always_comb begin
    o_grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (o_grant[i]) begin
        o_grant_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one registered ALU between NREQ requesters.
// Revision : 1.0
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*XLEN-1:0] i_req_rs1,
  input  logic [NREQ*XLEN-1:0] i_req_rs2,
  input  logic [NREQ*3-1:0]    i_req_funct3,
  input  logic [NREQ-1:0]      i_req_funct7,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [NREQ*XLEN-1:0] o_rsp_rd,
  output logic [NREQ-1:0]      o_rsp_z,
  output logic [XLEN-1:0]      o_alu_rs1,
  output logic [XLEN-1:0]      o_alu_rs2,
  output logic [2:0]           o_alu_funct3,
  output logic                 o_alu_funct7,
  input  logic [XLEN-1:0]      i_alu_rd,
  input  logic                 i_alu_z
);

  localparam int                IDX_W      = $clog2(NREQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0]     r_rr_ptr;
  logic [NREQ-1:0]      r_busy;
  logic [NREQ-1:0]      r_rsp_valid;
  logic [NREQ*XLEN-1:0] r_rsp_rd;
  logic [NREQ-1:0]      r_rsp_z;
  tag_t                 r_tag [LAT];

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_vld;
  logic [NREQ-1:0]  w_rsp_hs;
  logic [NREQ-1:0]  w_wr;
  tag_t             w_tag_out;
  logic [XLEN-1:0]  w_alu_rs1;
  logic [XLEN-1:0]  w_alu_rs2;
  logic [2:0]       w_alu_funct3;
  logic             w_alu_funct7;

  // Reset is included so the ALU shows the idle ADD while reset is asserted.
  assign w_elig   = i_req_valid & ~r_busy & {NREQ{~(i_flush | rst)}};
  assign w_rsp_hs = r_rsp_valid & i_rsp_ready;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req       (w_elig),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_gnt),
    .o_grant_idx (w_gnt_idx),
    .o_grant_vld (w_gnt_vld)
  );

  always_comb begin
    w_alu_rs1    = '0;
    w_alu_rs2    = '0;
    w_alu_funct3 = F3_ADD_SUB;
    w_alu_funct7 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_alu_rs1    = i_req_rs1[i*XLEN +: XLEN];
        w_alu_rs2    = i_req_rs2[i*XLEN +: XLEN];
        w_alu_funct3 = i_req_funct3[i*3 +: 3];
        w_alu_funct7 = i_req_funct7[i];
      end
    end
  end

  assign o_req_ready  = w_gnt;
  assign o_alu_rs1    = w_alu_rs1;
  assign o_alu_rs2    = w_alu_rs2;
  assign o_alu_funct3 = w_alu_funct3;
  assign o_alu_funct7 = w_alu_funct7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + IDX_W'(1);
    end
  end

  // Tag pipe tracks which requester owns the result emerging from the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0] <= {w_gnt_vld, TAG_IDX_W'(w_gnt_idx)};
      for (int s = 1; s < LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign w_tag_out = r_tag[LAT-1];

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_wr[i] = w_tag_out.valid && (w_tag_out.index == TAG_IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rd    <= '0;
      r_rsp_z     <= '0;
    end else if (i_flush) begin
      r_busy      <= '0;
      r_rsp_valid <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_rsp_hs[i]) begin
          r_busy[i] <= 1'b0;
        end
        if (w_wr[i]) begin
          r_rsp_valid[i]             <= 1'b1;
          r_rsp_rd[i*XLEN +: XLEN]   <= i_alu_rd;
          r_rsp_z[i]                 <= i_alu_z;
        end else if (w_rsp_hs[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rd    = r_rsp_rd;
  assign o_rsp_z     = r_rsp_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Randomized bench for alu_arbiter against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rs1 [N];
  logic [31:0] rs2 [N];
  logic [2:0]  f3  [N];
  logic        f7  [N];

  logic [1:0]  req_ready, rsp_valid, rsp_z;
  logic [63:0] rsp_rd;
  logic [31:0] alu_rs1, alu_rs2;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_rd_q;
  logic        alu_z_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2), .LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_rs1    ({rs1[1], rs1[0]}),
    .i_req_rs2    ({rs2[1], rs2[0]}),
    .i_req_funct3 ({f3[1], f3[0]}),
    .i_req_funct7 ({f7[1], f7[0]}),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rd     (rsp_rd),
    .o_rsp_z      (rsp_z),
    .o_alu_rs1    (alu_rs1),
    .o_alu_rs2    (alu_rs2),
    .o_alu_funct3 (alu_funct3),
    .o_alu_funct7 (alu_funct7),
    .i_alu_rd     (alu_rd_q),
    .i_alu_z      (alu_z_q)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic m,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return m ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return m ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Single-cycle registered ALU standing in for the core's instance.
  always @(posedge clk) begin
    alu_rd_q <= alu_f(alu_funct3, alu_funct7, alu_rs1, alu_rs2);
    alu_z_q  <= (alu_f(alu_funct3, alu_funct7, alu_rs1, alu_rs2) == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-requester busy/response state plus an in-flight list.
  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        z;
    int          left;
  } flight_t;

  flight_t     q[$];
  bit          m_busy [N];
  bit          m_val  [N];
  logic [31:0] m_rd   [N];
  logic        m_z    [N];
  int          m_ptr;

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_val[i] = 0; m_rd[i] = '0; m_z[i] = 1'b0;
    end
  endtask

  // Inputs are set by the caller at the falling edge; check, then advance the model.
  task automatic do_cycle();
    int g;
    logic [31:0] e_rs1, e_rs2;
    logic [2:0]  e_f3;
    logic        e_f7;
    #1;
    if (rst) model_reset();
    g = -1;
    if (!rst && !flush) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
      end
    end
    e_rs1 = (g >= 0) ? rs1[g] : 32'd0;
    e_rs2 = (g >= 0) ? rs2[g] : 32'd0;
    e_f3  = (g >= 0) ? f3[g]  : 3'd0;
    e_f7  = (g >= 0) ? f7[g]  : 1'b0;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(g == i));
      check_eq($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_val[i]));
      check_eq($sformatf("rsp_rd[%0d]", i), rsp_rd[i*32 +: 32], m_rd[i]);
      check_eq($sformatf("rsp_z[%0d]", i), 32'(rsp_z[i]), 32'(m_z[i]));
    end
    check_eq("alu_rs1", alu_rs1, e_rs1);
    check_eq("alu_rs2", alu_rs2, e_rs2);
    check_eq("alu_funct3", 32'(alu_funct3), 32'(e_f3));
    check_eq("alu_funct7", 32'(alu_funct7), 32'(e_f7));
    if (!rst) begin
      if (flush) begin
        q.delete();
        for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_val[i] = 0; end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (m_val[i] && rsp_ready[i]) begin m_val[i] = 0; m_busy[i] = 0; end
        end
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (q[k].left == 1) begin
            m_val[q[k].idx] = 1; m_rd[q[k].idx] = q[k].rd; m_z[q[k].idx] = q[k].z;
            q.delete(k);
          end else begin
            q[k].left--;
          end
        end
        if (g >= 0) begin
          flight_t f;
          f.idx = g; f.left = 1;
          f.rd  = alu_f(e_f3, e_f7, e_rs1, e_rs2);
          f.z   = (f.rd == 32'd0);
          q.push_back(f);
          m_busy[g] = 1;
          m_ptr = (g + 1) % N;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op, input logic m);
    req_valid[i] = v; rs1[i] = a; rs2[i] = b; f3[i] = op; f7[i] = m;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, 3'd0, 1'b0);
    model_reset();
    @(negedge clk);
    do_cycle();
    rst = 1'b0;
    rsp_ready = 2'b11;

    // Single ADD 20+30
    set_req(0, 1'b1, 32'd20, 32'd30, 3'd0, 1'b0);
    do_cycle();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    repeat (3) do_cycle();

    // Contention: SUB 8-3 and SLL 8<<3
    set_req(0, 1'b1, 32'd8, 32'd3, 3'd0, 1'b1);
    set_req(1, 1'b1, 32'd8, 32'd3, 3'd1, 1'b0);
    do_cycle(); do_cycle();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    repeat (3) do_cycle();

    // Back-pressure on requester 0 while requester 1 keeps issuing
    set_req(0, 1'b1, 32'd20, 32'd30, 3'd7, 1'b0);
    set_req(1, 1'b1, 32'd5, 32'd5, 3'd0, 1'b1);
    rsp_ready = 2'b10;
    repeat (7) do_cycle();
    rsp_ready = 2'b11;
    repeat (3) do_cycle();

    // Reset one cycle after a grant
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    repeat (3) do_cycle();
    set_req(1, 1'b1, 32'd1, 32'd2, 3'd0, 1'b0);
    do_cycle();
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    repeat (3) do_cycle();

    // Flush while requester 1 is in flight and requester 0 is waiting
    set_req(1, 1'b1, 32'd7, 32'd9, 3'd6, 1'b0);
    do_cycle();
    set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    set_req(0, 1'b1, 32'd4, 32'd4, 3'd4, 1'b0);
    flush = 1'b1;
    do_cycle();
    flush = 1'b0;
    do_cycle();
    set_req(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    repeat (3) do_cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 99) < 1);
      flush = ($urandom_range(0, 99) < 4);
      for (int i = 0; i < N; i++) begin
        logic [31:0] a, b;
        int sel;
        a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        sel = $urandom_range(0, 3);
        b   = (sel == 0) ? a : (sel == 1) ? 32'($urandom_range(0, 40)) : $urandom;
        set_req(i, ($urandom_range(0, 9) < 7), a, b, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        rsp_ready[i] = ($urandom_range(0, 9) < 6);
      end
      do_cycle();
    end
    rst = 1'b0;
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
